// File: rtl/ibex_sram_arb_pkg.sv
// ibex_sram_arb_pkg: owner/response types and address-window check shared by the SRAM arbiter.
package ibex_sram_arb_pkg;
  typedef enum logic {ArbInstr = 1'b0, ArbData = 1'b1} arb_owner_e;
  typedef struct packed {
    logic       valid;
    arb_owner_e owner;
    logic       we;
    logic       err;
  } rsp_t;
  // Unsigned wrap-around makes addresses below base land far outside the window.
  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base,
                                     input logic [31:0] size);
    return (addr - base) < size;
  endfunction
endpackage

// File: rtl/ibex_sram_arb_rr.sv
// ibex_sram_arb_rr: 2-way round-robin picker; req/gnt bit 0 = instr, bit 1 = data.
module ibex_sram_arb_rr
  import ibex_sram_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic       tie_o
);
  arb_owner_e rr_last_q, rr_last_d;
  assign tie_o = &req_i;
  always_comb begin
    gnt_o     = tie_o ? ((rr_last_q == ArbInstr) ? 2'b10 : 2'b01) : req_i;
    rr_last_d = tie_o ? (gnt_o[1] ? ArbData : ArbInstr) : rr_last_q;
  end
  // Starting at ArbInstr lets data win the first tie after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_last_q <= ArbInstr;
    else         rr_last_q <= rr_last_d;
  end
endmodule

// File: rtl/ibex_sram_arbiter.sv
// ibex_sram_arbiter: shares a 1-cycle-latency single-port SRAM between Ibex instr and data ports.
// Define IBEX_SRAM_ARB_STATS_EN to add saturating tie-cycle and out-of-window grant counters.
module ibex_sram_arbiter
  import ibex_sram_arb_pkg::*;
#(
  parameter logic [31:0] MemBase   = 32'h0010_0000,
  parameter logic [31:0] MemSize   = 32'h0001_0000,
  parameter int unsigned DataWidth = 33,
  localparam int unsigned AddrW    = $clog2(MemSize / 4)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 instr_req_i,
  output logic                 instr_gnt_o,
  input  logic [31:0]          instr_addr_i,
  output logic                 instr_rvalid_o,
  output logic [DataWidth-1:0] instr_rdata_o,
  output logic                 instr_err_o,
  input  logic                 data_req_i,
  output logic                 data_gnt_o,
  input  logic                 data_we_i,
  input  logic [3:0]           data_be_i,
  input  logic [31:0]          data_addr_i,
  input  logic [DataWidth-1:0] data_wdata_i,
  output logic                 data_rvalid_o,
  output logic [DataWidth-1:0] data_rdata_o,
  output logic                 data_err_o,
  output logic                 ram_req_o,
  output logic                 ram_we_o,
  output logic [AddrW-1:0]     ram_addr_o,
  output logic [DataWidth-1:0] ram_wdata_o,
  output logic [DataWidth-1:0] ram_wmask_o,
  input  logic [DataWidth-1:0] ram_rdata_i
`ifdef IBEX_SRAM_ARB_STATS_EN
  ,
  output logic [31:0]          stat_conflicts_o,
  output logic [31:0]          stat_errs_o
`endif
);
  logic [1:0]  gnt;
  logic        tie, any_gnt, sel_data, win, full, rd_ok;
  logic [31:0] addr, offset;
  rsp_t        rsp_d, rsp_q;

  ibex_sram_arb_rr u_rr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  ({data_req_i, instr_req_i}),
    .gnt_o  (gnt),
    .tie_o  (tie)
  );

  assign instr_gnt_o = gnt[0];
  assign data_gnt_o  = gnt[1];
  assign any_gnt     = |gnt;
  assign sel_data    = gnt[1];
  assign addr        = sel_data ? data_addr_i : instr_addr_i;
  assign offset      = addr - MemBase;
  assign win         = in_window(addr, MemBase, MemSize);
  assign full        = data_be_i == 4'hF;

  assign ram_req_o   = any_gnt & win;
  assign ram_we_o    = ram_req_o & sel_data & data_we_i;
  assign ram_addr_o  = AddrW'(offset >> 2);
  // Tag is always written; a partial write clears it.
  assign ram_wdata_o = {data_wdata_i[DataWidth-1:32] & {(DataWidth-32){full}}, data_wdata_i[31:0]};
  assign ram_wmask_o = ram_we_o ? {{(DataWidth-32){1'b1}}, {8{data_be_i[3]}}, {8{data_be_i[2]}},
                                   {8{data_be_i[1]}}, {8{data_be_i[0]}}} : '0;

  always_comb begin
    rsp_d.valid = any_gnt;
    rsp_d.owner = sel_data ? ArbData : ArbInstr;
    rsp_d.we    = sel_data & data_we_i;
    rsp_d.err   = any_gnt & ~win;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rsp_q <= '0;
    else         rsp_q <= rsp_d;
  end

  assign rd_ok          = ~rsp_q.we & ~rsp_q.err;
  assign instr_rvalid_o = rsp_q.valid & (rsp_q.owner == ArbInstr);
  assign data_rvalid_o  = rsp_q.valid & (rsp_q.owner == ArbData);
  assign instr_err_o    = instr_rvalid_o & rsp_q.err;
  assign data_err_o     = data_rvalid_o & rsp_q.err;
  assign instr_rdata_o  = (instr_rvalid_o & rd_ok) ? ram_rdata_i : '0;
  assign data_rdata_o   = (data_rvalid_o & rd_ok) ? ram_rdata_i : '0;

`ifdef IBEX_SRAM_ARB_STATS_EN
  logic [31:0] stat_conflicts_q, stat_errs_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_conflicts_q <= '0;
      stat_errs_q      <= '0;
    end else begin
      if (tie && !(&stat_conflicts_q)) stat_conflicts_q <= stat_conflicts_q + 32'd1;
      if (rsp_d.err && !(&stat_errs_q)) stat_errs_q <= stat_errs_q + 32'd1;
    end
  end
  assign stat_conflicts_o = stat_conflicts_q;
  assign stat_errs_o      = stat_errs_q;
`endif
endmodule

// File: tb/tb_ibex_sram_arbiter.sv
// tb_ibex_sram_arbiter: scoreboard bench for ibex_sram_arbiter with a behavioural 1-cycle RAM.
// Define IBEX_SRAM_ARB_STATS_EN to also exercise the statistics counters.
module tb_ibex_sram_arbiter;
  localparam logic [31:0] MB = 32'h0010_0000;
  localparam logic [31:0] MS = 32'h0001_0000;
  localparam int AW = 14;

  typedef struct packed {
    int          due;
    logic        owner;
    logic [32:0] rdata;
    logic        err;
  } exp_t;

  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic instr_req_i = 0, data_req_i = 0, data_we_i = 0;
  logic [31:0] instr_addr_i = 0, data_addr_i = 0;
  logic [3:0]  data_be_i = 0;
  logic [32:0] data_wdata_i = 0, ram_rdata_i = 0;
  logic instr_gnt_o, instr_rvalid_o, instr_err_o, data_gnt_o, data_rvalid_o, data_err_o;
  logic ram_req_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [32:0] instr_rdata_o, data_rdata_o, ram_wdata_o, ram_wmask_o;
`ifdef IBEX_SRAM_ARB_STATS_EN
  logic [31:0] stat_conflicts_o, stat_errs_o;
`endif

  int errors = 0, checks = 0, cyc = 0;
  bit in_reset = 1'b1;
  exp_t q[$];
  exp_t me;
  logic [32:0] ram_mem [2**AW];
  logic [32:0] ref_mem [2**AW];

  ibex_sram_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_addr_i(instr_addr_i),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_wmask_o(ram_wmask_o), .ram_rdata_i(ram_rdata_i)
`ifdef IBEX_SRAM_ARB_STATS_EN
    , .stat_conflicts_o(stat_conflicts_o), .stat_errs_o(stat_errs_o)
`endif
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  always @(posedge clk_i)
    if (ram_req_o) begin
      if (ram_we_o) ram_mem[ram_addr_o] <= (ram_mem[ram_addr_o] & ~ram_wmask_o) | (ram_wdata_o & ram_wmask_o);
      else          ram_rdata_i <= ram_mem[ram_addr_o];
    end

  // Response monitor: every due scoreboard entry must appear on its owner's port only.
  always @(negedge clk_i)
    if (!in_reset) begin
      checks++;
      if (q.size() > 0 && q[0].due == cyc) begin
        me = q.pop_front();
        if (me.owner ? !(data_rvalid_o === 1'b1 && instr_rvalid_o === 1'b0 && data_rdata_o === me.rdata &&
                         data_err_o === me.err && instr_rdata_o === 33'h0)
                     : !(instr_rvalid_o === 1'b1 && data_rvalid_o === 1'b0 && instr_rdata_o === me.rdata &&
                         instr_err_o === me.err && data_rdata_o === 33'h0)) begin
          errors++;
          $display("FAIL rsp cyc=%0d owner=%0b: got iv=%b dv=%b ird=%h drd=%h ie=%b de=%b, exp rdata=%h err=%b",
                   cyc, me.owner, instr_rvalid_o, data_rvalid_o, instr_rdata_o, data_rdata_o,
                   instr_err_o, data_err_o, me.rdata, me.err);
        end
      end else if (instr_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0) begin
        errors++;
        $display("FAIL spurious_rvalid cyc=%0d: got iv=%b dv=%b, exp 0 0", cyc, instr_rvalid_o, data_rvalid_o);
      end
    end

  function automatic logic [32:0] pat(input int i);
    return {i[0], 32'hC0DE_0000 | 32'(i)};
  endfunction

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                       input logic [3:0] dbe, input logic [31:0] da, input logic [32:0] dwd,
                       input logic eg_i, input logic eg_d);
    logic [31:0] a;
    logic win;
    int idx;
    exp_t e;
    @(negedge clk_i);
    instr_req_i = ir; instr_addr_i = ia;
    data_req_i = dr; data_we_i = dwe; data_be_i = dbe; data_addr_i = da; data_wdata_i = dwd;
    #1;
    checks++;
    if ({instr_gnt_o, data_gnt_o} !== {eg_i, eg_d}) begin
      errors++;
      $display("FAIL gnt cyc=%0d: got i=%b d=%b, exp i=%b d=%b", cyc, instr_gnt_o, data_gnt_o, eg_i, eg_d);
    end
    a = eg_d ? da : ia;
    win = (a - MB) < MS;
    idx = int'((a - MB) >> 2) % (2**AW);
    checks++;
    if (ram_req_o !== ((eg_i | eg_d) & win) || ram_we_o !== (eg_d & dwe & win) ||
        (((eg_i | eg_d) & win) && ram_addr_o !== AW'(idx))) begin
      errors++;
      $display("FAIL ram_ctl cyc=%0d: got req=%b we=%b addr=%0d, exp req=%b we=%b addr=%0d",
               cyc, ram_req_o, ram_we_o, ram_addr_o, (eg_i | eg_d) & win, eg_d & dwe & win, idx);
    end
    if (eg_i | eg_d) begin
      e.due = cyc + 1;
      e.owner = eg_d;
      e.err = !win;
      e.rdata = (!win || (eg_d && dwe)) ? 33'h0 : ref_mem[idx];
      if (win && eg_d && dwe) begin
        for (int b = 0; b < 4; b++) if (dbe[b]) ref_mem[idx][8*b +: 8] = dwd[8*b +: 8];
        ref_mem[idx][32] = (dbe == 4'hF) ? dwd[32] : 1'b0;
      end
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    in_reset = 1'b1;
    q.delete();
    instr_req_i = 0; data_req_i = 0; data_we_i = 0;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o, ram_req_o, ram_we_o} !== 8'h0 ||
        instr_rdata_o !== 33'h0 || data_rdata_o !== 33'h0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b%b rv=%b%b err=%b%b req=%b we=%b ird=%h drd=%h, exp all 0",
               instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o,
               ram_req_o, ram_we_o, instr_rdata_o, data_rdata_o);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1 in_reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_instr_read();
    drive(1, MB + 8, 0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (ram_addr_o !== AW'(2)) begin
      errors++;
      $display("FAIL instr_ram_addr: got %0d, exp 2", ram_addr_o);
    end
    drive(1, MB + 7, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 4; i++) drive(1, MB + 12, 1, 0, 4'hF, MB + 16, 0, i[0], !i[0]);
    idle(2);
  endtask

  task automatic test_write_mask();
    drive(0, 0, 1, 1, 4'h3, MB + 20, 33'h1_DEAD_BEEF, 0, 1);
    checks++;
    if (ram_wmask_o !== 33'h1_0000_FFFF || ram_wdata_o[32] !== 1'b0) begin
      errors++;
      $display("FAIL wmask_partial: got mask=%h wdata=%h, exp mask=1_0000ffff tag=0", ram_wmask_o, ram_wdata_o);
    end
    drive(0, 0, 1, 1, 4'hF, MB + 24, 33'h1_1234_5678, 0, 1);
    checks++;
    if (ram_wmask_o !== 33'h1_FFFF_FFFF || ram_wdata_o !== 33'h1_1234_5678) begin
      errors++;
      $display("FAIL wmask_full: got mask=%h wdata=%h, exp mask=1_ffffffff wdata=1_12345678", ram_wmask_o, ram_wdata_o);
    end
    drive(0, 0, 1, 0, 4'hF, MB + 20, 0, 0, 1);
    drive(0, 0, 1, 0, 4'hF, MB + 24, 0, 0, 1);
    idle(2);
  endtask

  task automatic test_out_of_window();
    drive(0, 0, 1, 0, 4'hF, MB + MS, 0, 0, 1);
    drive(1, MB - 4, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 1, 4'hF, MB + MS + 4, 33'h1_FFFF_FFFF, 0, 1);
    drive(1, MB + MS - 4, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
  endtask

  task automatic test_back_to_back();
    drive(1, MB + 32, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 0, 4'hF, MB + 36, 0, 0, 1);
    drive(0, 0, 1, 1, 4'hC, MB + 36, 33'h0_AABB_CCDD, 0, 1);
    drive(1, MB + 36, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 0, 4'h0, MB + 36, 0, 0, 1);
    idle(2);
  endtask

  task automatic test_reset_mid();
    drive(1, MB + 40, 1, 0, 4'hF, MB + 44, 0, 0, 1);
    @(posedge clk_i);
    #1;
    do_reset();
    drive(1, MB + 40, 1, 0, 4'hF, MB + 44, 0, 0, 1);
    idle(2);
  endtask

`ifdef IBEX_SRAM_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 3; i++) drive(1, MB + 48, 1, 0, 4'hF, MB + 52, 0, i[0], !i[0]);
    drive(1, MB + MS, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 0, 4'hF, 32'h0, 0, 0, 1);
    idle(2);
    checks++;
    if (stat_conflicts_o !== 32'd3 || stat_errs_o !== 32'd2) begin
      errors++;
      $display("FAIL stats: got conflicts=%0d errs=%0d, exp 3 2", stat_conflicts_o, stat_errs_o);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      ram_mem[i] = pat(i);
      ref_mem[i] = pat(i);
    end
    test_reset();
    test_instr_read();
    test_round_robin();
    test_write_mask();
    test_out_of_window();
    test_back_to_back();
    test_reset_mid();
`ifdef IBEX_SRAM_ARB_STATS_EN
    test_stats();
`endif
    idle(2);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending responses, exp 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
